execute_unit_alu: RTL and testbench
===================================

EXECUTE_UNIT_ALU -- requirements
Module: execute_unit_alu

Interface
REQ-001 Parameters SHALL be: XLEN, default 64, datapath width (32 or 64); ADDR_W, default 32, instruction address width; PID_W, default 2, width of the way/pipeline ID tag.
REQ-002 Clock and reset SHALL be: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-003 Upstream inputs SHALL be: valid_i  in  1  request valid; ready_o  out  1  unit can accept a request.
REQ-004 Upstream payload SHALL be: instAddr_i  in  ADDR_W  PC; rdAddr_i  in  5  destination register; rdWriteEnable_i  in  1  writeback request; rs1ReadData_i / rs2ReadData_i  in  XLEN  operands; imm_i  in  XLEN  sign-extended immediate; opCode_i  in  7; funct3_i  in  3; funct7_i  in  7; shamt_i  in  6; pID_i  in  PID_W  tag.
REQ-005 Downstream outputs SHALL be: valid_o  out  1  result valid; ready_i  in  1  consumer accepts; rdAddr_o  out  5; rdWriteEnable_o  out  1; rdWriteData_o  out  XLEN  result; instAddr_o  out  ADDR_W; pID_o  out  PID_W; illegal_o  out  1  unsupported opcode/funct.

Function
REQ-006 Transfer SHALL occur upstream when valid_i && ready_o and downstream when valid_o && ready_i, both on the rising clk edge.
REQ-007 Latency SHALL be exactly 1 cycle: a request accepted at edge N SHALL be presented on the outputs after edge N, with no downstream stall.
REQ-008 Supported opcodes SHALL be: OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111; with XLEN=64, also OP-32 0111011 and OP-IMM-32 0011011.
REQ-009 ALU ops SHALL be ADD, SUB (funct7=0100000, OP only), SLL, SLT, SLTU, XOR, SRL, SRA (funct7[5]=1), OR and AND, per funct3.
REQ-010 Shift amount SHALL be: shamt_i[5:0] for OP-IMM at XLEN=64; rs2[5:0] for OP at XLEN=64; the low 5 bits for W-ops and at XLEN=32.
REQ-011 W-op results SHALL be computed on the low 32 bits and sign-extended from bit 31 to XLEN; SRAW SHALL shift in bit 31.
REQ-012 LUI SHALL produce imm_i; AUIPC SHALL produce zero-extended instAddr_i + imm_i, truncated to XLEN.
REQ-013 All arithmetic SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-014 An unsupported opcode or funct SHALL produce rdWriteData_o=0, rdWriteEnable_o=0 and illegal_o=1; the request is still passed downstream in order.
REQ-015 Every other output field SHALL equal the accepted request's fields unchanged.
REQ-016 Buffering SHALL be a 2-entry skid (main + skid register) with states EMPTY, ONE and FULL:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on drain without accept.
  - ONE -> FULL on accept while ready_i=0.
  - FULL -> ONE on drain.
REQ-017 ready_o SHALL be registered and SHALL be 0 only in state FULL, so it has no combinational path from ready_i.
REQ-018 Simultaneous accept and drain in ONE SHALL stay in ONE and load the new result into main.
REQ-019 In FULL, the skid entry SHALL move to main on drain; ordering SHALL be strictly FIFO.
REQ-020 While valid_o=1 && ready_i=0, all outputs SHALL hold stable.

Reset
REQ-021 On rst=1 at a clk edge, state SHALL become EMPTY, valid_o=0 and ready_o=1.
REQ-022 On reset, rdWriteEnable_o=0, illegal_o=0, and rdWriteData_o, rdAddr_o, instAddr_o and pID_o SHALL all be 0.
REQ-023 Reset mid-operation SHALL discard all buffered entries; no result from before reset SHALL appear afterwards.

Structure
REQ-024 A shared package exe_pkg SHALL hold opcode constants, funct3 constants and the skid state enum.
REQ-025 Sub-module alu_core SHALL be purely combinational (operands, opcode/funct, shamt -> result, illegal), parametrised by XLEN.

Verification
REQ-026 ADD: rs1=0x7FFF_FFFF_FFFF_FFFF, rs2=1, OP, funct3=000 -> rdWriteData_o=0x8000_0000_0000_0000 one cycle later.
REQ-027 ADDW: rs1=0x0000_0000_7FFF_FFFF, rs2=1, OP-32 -> 0xFFFF_FFFF_8000_0000; SRAI rs1=0x8000_0000_0000_0000, shamt=63 -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-028 AUIPC: instAddr=0x8000_0000, imm=0x1000 -> 0x8000_1000; LUI imm=0xFFFF_FFFF_FFFF_F000 -> same value.
REQ-029 Backpressure: ready_i=0; three back-to-back requests tagged pID 0,1,2 -> ready_o falls after the second; releasing ready_i delivers 0,1,2 in order, with none lost or duplicated.
REQ-030 Illegal: opCode=0000000 -> illegal_o=1, rdWriteEnable_o=0, rdWriteData_o=0.
REQ-031 Reset with FULL state and ready_i=0 -> next cycle valid_o=0, ready_o=1; first output after reset is the first request sent after reset.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared constants for the integer execute unit: RISC-V opcodes, funct3/funct7
// encodings and the output skid-buffer state.
package exe_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational integer ALU: decodes opcode/funct, selects operands and
// shift amount, and produces the result plus an illegal-instruction flag.
module alu_core
  import exe_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [XLEN-1:0]   imm,
  input  logic [ADDR_W-1:0] pc,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [5:0]        shamt,
  output logic [XLEN-1:0]   result,
  output logic              illegal
);

  localparam bit HAS_W = (XLEN == 64);

  logic                   reg_form;
  logic                   word_form;
  logic [XLEN-1:0]        op_b;
  logic [5:0]             sh_raw;
  logic [5:0]             sh;
  logic [6:0]             f7_shift;
  logic                   legal;
  logic                   use_sub;
  logic                   use_sra;
  logic signed [XLEN-1:0] full_sra;
  logic [XLEN-1:0]        full_res;
  logic signed [31:0]     word_sra;
  logic [31:0]            word_res;
  logic [XLEN-1:0]        raw_res;

  always_comb begin
    reg_form  = (opcode == OPC_OP) || (opcode == OPC_OP_32);
    word_form = HAS_W && ((opcode == OPC_OP_32) || (opcode == OPC_OP_IMM_32));
    op_b      = reg_form ? rs2 : imm;
    sh_raw    = reg_form ? rs2[5:0] : shamt;
    sh        = (word_form || !HAS_W) ? {1'b0, sh_raw[4:0]} : sh_raw;
  end

  // At XLEN=64 funct7[0] of an immediate shift is shamt[5], not an opcode bit.
  assign f7_shift = HAS_W ? {funct7[6:1], 1'b0} : funct7;

  always_comb begin
    legal   = 1'b0;
    use_sub = 1'b0;
    use_sra = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal   = (funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
        use_sub = (funct7 == F7_ALT);
        use_sra = (funct7 == F7_ALT);
      end
      OPC_OP_IMM: begin
        legal   = ((funct3 != F3_SLL) && (funct3 != F3_SR)) ||
                  (f7_shift == F7_BASE) ||
                  ((funct3 == F3_SR) && (f7_shift == F7_ALT));
        use_sra = (f7_shift == F7_ALT);
      end
      OPC_OP_32, OPC_OP_IMM_32: begin
        legal   = HAS_W && (
                    ((funct3 == F3_ADD) && ((opcode == OPC_OP_IMM_32) ||
                                            (funct7 == F7_BASE) || (funct7 == F7_ALT))) ||
                    ((funct3 == F3_SLL) && (funct7 == F7_BASE)) ||
                    ((funct3 == F3_SR)  && ((funct7 == F7_BASE) || (funct7 == F7_ALT))));
        use_sub = (opcode == OPC_OP_32) && (funct7 == F7_ALT);
        use_sra = (funct7 == F7_ALT);
      end
      OPC_LUI, OPC_AUIPC: legal = 1'b1;
      default:            legal = 1'b0;
    endcase
  end

  always_comb begin
    full_sra = $signed(rs1) >>> sh;
    full_res = '0;
    case (funct3)
      F3_ADD:  full_res = use_sub ? (rs1 - op_b) : (rs1 + op_b);
      F3_SLL:  full_res = rs1 << sh;
      F3_SLT:  full_res = XLEN'($signed(rs1) < $signed(op_b));
      F3_SLTU: full_res = XLEN'(rs1 < op_b);
      F3_XOR:  full_res = rs1 ^ op_b;
      F3_SR:   full_res = use_sra ? full_sra : (rs1 >> sh);
      F3_OR:   full_res = rs1 | op_b;
      F3_AND:  full_res = rs1 & op_b;
      default: full_res = '0;
    endcase
  end

  // The arithmetic shift is computed on its own so the signed operand is not
  // coerced to unsigned by the surrounding mux.
  always_comb begin
    word_sra = $signed(rs1[31:0]) >>> sh[4:0];
    word_res = '0;
    case (funct3)
      F3_ADD:  word_res = use_sub ? (rs1[31:0] - op_b[31:0]) : (rs1[31:0] + op_b[31:0]);
      F3_SLL:  word_res = rs1[31:0] << sh[4:0];
      F3_SR:   word_res = use_sra ? word_sra : (rs1[31:0] >> sh[4:0]);
      default: word_res = '0;
    endcase
  end

  always_comb begin
    raw_res = full_res;
    if (word_form) begin
      raw_res = XLEN'($signed(word_res));
    end else if (opcode == OPC_LUI) begin
      raw_res = imm;
    end else if (opcode == OPC_AUIPC) begin
      raw_res = XLEN'(pc) + imm;
    end
    result  = legal ? raw_res : '0;
    illegal = !legal;
  end

endmodule

// File: rtl/execute_unit_alu.sv
// Single-cycle integer execute stage: ALU result registered into a 2-entry
// skid buffer so ready_o is a flop with no path from ready_i.
module execute_unit_alu
  import exe_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32,
  parameter int PID_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] instAddr_i,
  input  logic [4:0]        rdAddr_i,
  input  logic              rdWriteEnable_i,
  input  logic [XLEN-1:0]   rs1ReadData_i,
  input  logic [XLEN-1:0]   rs2ReadData_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [6:0]        opCode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [5:0]        shamt_i,
  input  logic [PID_W-1:0]  pID_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [4:0]        rdAddr_o,
  output logic              rdWriteEnable_o,
  output logic [XLEN-1:0]   rdWriteData_o,
  output logic [ADDR_W-1:0] instAddr_o,
  output logic [PID_W-1:0]  pID_o,
  output logic              illegal_o
);

  typedef struct packed {
    logic [4:0]        rd_addr;
    logic              rd_we;
    logic [XLEN-1:0]   rd_data;
    logic [ADDR_W-1:0] inst_addr;
    logic [PID_W-1:0]  pid;
    logic              illegal;
  } entry_t;

  skid_state_e     state_q;
  skid_state_e     state_d;
  entry_t          main_q;
  entry_t          skid_q;
  entry_t          incoming;
  logic            ready_q;
  logic [XLEN-1:0] alu_result;
  logic            alu_illegal;
  logic            accept;
  logic            drain;
  logic            load_main;
  logic            load_skid;
  logic            promote_skid;

  alu_core #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_alu_core (
    .rs1     (rs1ReadData_i),
    .rs2     (rs2ReadData_i),
    .imm     (imm_i),
    .pc      (instAddr_i),
    .opcode  (opCode_i),
    .funct3  (funct3_i),
    .funct7  (funct7_i),
    .shamt   (shamt_i),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  assign incoming = '{
    rd_addr:   rdAddr_i,
    rd_we:     rdWriteEnable_i && !alu_illegal,
    rd_data:   alu_result,
    inst_addr: instAddr_i,
    pid:       pID_i,
    illegal:   alu_illegal
  };

  assign accept = valid_i && ready_q;
  assign drain  = (state_q != SKID_EMPTY) && ready_i;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    promote_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d   = SKID_ONE;
          load_main = 1'b1;
        end
      end
      SKID_ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = SKID_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (drain) begin
          state_d      = SKID_ONE;
          promote_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b1;
      // NOTE: the data registers are reset too because the outputs must read
      // zero after reset, not just be marked invalid.
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID_FULL);
      if (load_main) begin
        main_q <= incoming;
      end else if (promote_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= incoming;
      end
    end
  end

  assign ready_o         = ready_q;
  assign valid_o         = (state_q != SKID_EMPTY);
  assign rdAddr_o        = main_q.rd_addr;
  assign rdWriteEnable_o = main_q.rd_we;
  assign rdWriteData_o   = main_q.rd_data;
  assign instAddr_o      = main_q.inst_addr;
  assign pID_o           = main_q.pid;
  assign illegal_o       = main_q.illegal;

endmodule

// File: tb/tb_execute_unit_alu.sv
// Self-checking bench for execute_unit_alu: directed RV64 cases, backpressure,
// reset while full, and randomized traffic against a queue-based reference.
module tb_execute_unit_alu;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  shamt;
    logic [1:0]  pid;
  } req_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic [31:0] pc;
    logic [1:0]  pid;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] instAddr_i = '0;
  logic [4:0]  rdAddr_i = '0;
  logic        rdWriteEnable_i = 1'b0;
  logic [63:0] rs1ReadData_i = '0;
  logic [63:0] rs2ReadData_i = '0;
  logic [63:0] imm_i = '0;
  logic [6:0]  opCode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [5:0]  shamt_i = '0;
  logic [1:0]  pID_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [4:0]  rdAddr_o;
  logic        rdWriteEnable_o;
  logic [63:0] rdWriteData_o;
  logic [31:0] instAddr_o;
  logic [1:0]  pID_o;
  logic        illegal_o;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [1:0] delivered[$];

  execute_unit_alu #(.XLEN(64), .ADDR_W(32), .PID_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .instAddr_i      (instAddr_i),
    .rdAddr_i        (rdAddr_i),
    .rdWriteEnable_i (rdWriteEnable_i),
    .rs1ReadData_i   (rs1ReadData_i),
    .rs2ReadData_i   (rs2ReadData_i),
    .imm_i           (imm_i),
    .opCode_i        (opCode_i),
    .funct3_i        (funct3_i),
    .funct7_i        (funct7_i),
    .shamt_i         (shamt_i),
    .pID_i           (pID_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .rdAddr_o        (rdAddr_o),
    .rdWriteEnable_o (rdWriteEnable_o),
    .rdWriteData_o   (rdWriteData_o),
    .instAddr_o      (instAddr_o),
    .pID_o           (pID_o),
    .illegal_o       (illegal_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] sra64(input logic [63:0] a, input int sh);
    logic [63:0] r;
    r = a >> sh;
    if (a[63]) r = r | ~({64{1'b1}} >> sh);
    return r;
  endfunction

  function automatic logic [31:0] sra32(input logic [31:0] a, input int sh);
    logic [31:0] r;
    r = a >> sh;
    if (a[31]) r = r | ~({32{1'b1}} >> sh);
    return r;
  endfunction

  function automatic logic [63:0] full_op(input logic [2:0] f3, input bit alt,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input int sh);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
      3'd3:    return (a < b) ? 64'd1 : 64'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? sra64(a, sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] word_op(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input int sh);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << sh;
      3'd5:    return alt ? sra32(a, sh) : a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t model(input req_t r);
    exp_t        e;
    logic [63:0] res;
    logic [31:0] w;
    bit          ok;
    bit          alt;
    res = '0;
    ok  = 1'b1;
    alt = (r.f7 == 7'b0100000);
    case (r.opc)
      OP: begin
        ok  = (r.f7 == 7'd0) || (alt && (r.f3 == 3'd0 || r.f3 == 3'd5));
        res = full_op(r.f3, alt, r.rs1, r.rs2, int'(r.rs2[5:0]));
      end
      OP_IMM: begin
        if (r.f3 == 3'd1) ok = (r.f7[6:1] == 6'd0);
        else if (r.f3 == 3'd5) ok = (r.f7[6:1] == 6'd0) || (r.f7[6:1] == 6'b010000);
        res = full_op(r.f3, (r.f3 == 3'd5) && (r.f7[6:1] == 6'b010000),
                      r.rs1, r.imm, int'(r.shamt));
      end
      OP_32: begin
        if (r.f3 == 3'd0 || r.f3 == 3'd5) ok = (r.f7 == 7'd0) || alt;
        else if (r.f3 == 3'd1) ok = (r.f7 == 7'd0);
        else ok = 1'b0;
        w   = word_op(r.f3, alt, r.rs1[31:0], r.rs2[31:0], int'(r.rs2[4:0]));
        res = {{32{w[31]}}, w};
      end
      OP_IMM_32: begin
        if (r.f3 == 3'd0) ok = 1'b1;
        else if (r.f3 == 3'd1) ok = (r.f7 == 7'd0);
        else if (r.f3 == 3'd5) ok = (r.f7 == 7'd0) || alt;
        else ok = 1'b0;
        w   = word_op(r.f3, (r.f3 == 3'd5) && alt, r.rs1[31:0], r.imm[31:0],
                      int'(r.shamt[4:0]));
        res = {{32{w[31]}}, w};
      end
      LUI:     res = r.imm;
      AUIPC:   res = {32'd0, r.pc} + r.imm;
      default: ok = 1'b0;
    endcase
    e.rd   = r.rd;
    e.we   = r.we && ok;
    e.data = ok ? res : 64'd0;
    e.pc   = r.pc;
    e.pid  = r.pid;
    e.ill  = !ok;
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic req_t mk(input logic [6:0] opc, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [63:0] rs1,
                              input logic [63:0] rs2, input logic [63:0] imm,
                              input logic [5:0] shamt, input logic [31:0] pc);
    req_t r;
    r.pc = pc; r.rd = 5'd7; r.we = 1'b1; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    r.opc = opc; r.f3 = f3; r.f7 = f7; r.shamt = shamt; r.pid = 2'd0;
    return r;
  endfunction

  function automatic req_t rand_req(input logic [1:0] pid);
    req_t        r;
    logic [11:0] i12;
    r.pc  = $urandom;
    r.rd  = 5'($urandom);
    r.we  = 1'($urandom);
    r.rs1 = {$urandom, $urandom};
    r.rs2 = {$urandom, $urandom};
    i12   = 12'($urandom);
    r.imm = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : {{52{i12[11]}}, i12};
    case ($urandom_range(0, 9))
      0, 1:    r.opc = OP;
      2, 3:    r.opc = OP_IMM;
      4:       r.opc = LUI;
      5:       r.opc = AUIPC;
      6:       r.opc = OP_32;
      7:       r.opc = OP_IMM_32;
      8:       r.opc = 7'b0000000;
      default: r.opc = 7'($urandom);
    endcase
    r.f3 = 3'($urandom);
    case ($urandom_range(0, 4))
      0, 1:    r.f7 = 7'b0000000;
      2:       r.f7 = 7'b0100000;
      3:       r.f7 = 7'b0100001;
      default: r.f7 = 7'($urandom);
    endcase
    r.shamt = 6'($urandom);
    r.pid   = pid;
    return r;
  endfunction

  task automatic drive(input bit v, input req_t r);
    valid_i         = v;
    instAddr_i      = r.pc;
    rdAddr_i        = r.rd;
    rdWriteEnable_i = r.we;
    rs1ReadData_i   = r.rs1;
    rs2ReadData_i   = r.rs2;
    imm_i           = r.imm;
    opCode_i        = r.opc;
    funct3_i        = r.f3;
    funct7_i        = r.f7;
    shamt_i         = r.shamt;
    pID_i           = r.pid;
  endtask

  // One clock: drive on the falling edge, compare outputs against the model
  // queue, and account for the handshakes that the next rising edge performs.
  task automatic step(input bit v, input req_t r, input bit rdy, output bit acc);
    exp_t obs;
    @(negedge clk);
    drive(v, r);
    ready_i = rdy;
    obs = {rdAddr_o, rdWriteEnable_o, rdWriteData_o, instAddr_o, pID_o, illegal_o};
    checks++;
    if (valid_o !== (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL valid_o got=%b exp=%b", valid_o, exp_q.size() != 0);
    end
    checks++;
    if (ready_o !== (exp_q.size() < 2)) begin
      failures++;
      $display("FAIL ready_o got=%b exp=%b", ready_o, exp_q.size() < 2);
    end
    if (valid_o === 1'b1 && exp_q.size() != 0) begin
      checks++;
      if (obs !== exp_q[0]) begin
        failures++;
        $display("FAIL out_payload got=%h exp=%h", obs, exp_q[0]);
      end
    end
    acc = v && (ready_o === 1'b1);
    if (valid_o === 1'b1 && rdy && exp_q.size() != 0) begin
      delivered.push_back(exp_q[0].pid);
      void'(exp_q.pop_front());
    end
    if (acc) exp_q.push_back(model(r));
  endtask

  task automatic send_directed(input req_t r, input logic [63:0] exp_data,
                               input bit exp_ill, input string name);
    @(negedge clk);
    drive(1'b1, r);
    ready_i = 1'b1;
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready got=%b exp=1", name, ready_o);
    end
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || rdWriteData_o !== exp_data || illegal_o !== exp_ill ||
        rdWriteEnable_o !== !exp_ill) begin
      failures++;
      $display("FAIL %s got v=%b data=%h ill=%b we=%b exp v=1 data=%h ill=%b we=%b",
               name, valid_o, rdWriteData_o, illegal_o, rdWriteEnable_o,
               exp_data, exp_ill, !exp_ill);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake got v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
    checks++;
    if ({rdAddr_o, rdWriteEnable_o, rdWriteData_o, instAddr_o, pID_o, illegal_o} !== '0) begin
      failures++;
      $display("FAIL reset_payload got rd=%h we=%b data=%h pc=%h pid=%h ill=%b exp all 0",
               rdAddr_o, rdWriteEnable_o, rdWriteData_o, instAddr_o, pID_o, illegal_o);
    end
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_directed();
    send_directed(mk(OP, 3'd0, 7'h00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 6'd0, 32'd0),
                  64'h8000_0000_0000_0000, 1'b0, "add_wrap");
    send_directed(mk(OP, 3'd0, 7'h20, 64'd0, 64'd1, 64'd0, 6'd0, 32'd0),
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sub");
    send_directed(mk(OP_32, 3'd0, 7'h00, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'd0, 6'd0, 32'd0),
                  64'hFFFF_FFFF_8000_0000, 1'b0, "addw");
    send_directed(mk(OP_IMM, 3'd5, 7'b0100001, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 6'd63,
                     32'd0), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "srai63");
    send_directed(mk(OP, 3'd1, 7'h00, 64'd1, 64'd65, 64'd0, 6'd0, 32'd0),
                  64'd2, 1'b0, "sll_rs2_low6");
    send_directed(mk(OP, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 6'd0, 32'd0),
                  64'd1, 1'b0, "slt");
    send_directed(mk(OP, 3'd3, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 6'd0, 32'd0),
                  64'd0, 1'b0, "sltu");
    send_directed(mk(OP_32, 3'd5, 7'h20, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'd0, 6'd0, 32'd0),
                  64'hFFFF_FFFF_F800_0000, 1'b0, "sraw");
    send_directed(mk(AUIPC, 3'd0, 7'h00, 64'd0, 64'd0, 64'h1000, 6'd0, 32'h8000_0000),
                  64'h0000_0000_8000_1000, 1'b0, "auipc");
    send_directed(mk(LUI, 3'd0, 7'h00, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_F000, 6'd0, 32'd0),
                  64'hFFFF_FFFF_FFFF_F000, 1'b0, "lui");
    send_directed(mk(7'b0000000, 3'd0, 7'h00, 64'd5, 64'd6, 64'd7, 6'd0, 32'd0),
                  64'd0, 1'b1, "illegal_opcode");
    send_directed(mk(OP, 3'd4, 7'h20, 64'd5, 64'd6, 64'd0, 6'd0, 32'd0),
                  64'd0, 1'b1, "illegal_funct7");
  endtask

  task automatic test_backpressure();
    req_t r0, r1, r2;
    bit   acc;
    delivered.delete();
    r0 = rand_req(2'd0); r1 = rand_req(2'd1); r2 = rand_req(2'd2);
    step(1'b1, r0, 1'b0, acc);
    step(1'b1, r1, 1'b0, acc);
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_low got=%b exp=0", ready_o);
    end
    step(1'b1, r2, 1'b0, acc);
    step(1'b1, r2, 1'b1, acc);
    step(1'b1, r2, 1'b1, acc);
    checks++;
    if (acc !== 1'b1) begin
      failures++;
      $display("FAIL bp_third_accept got=%b exp=1", acc);
    end
    step(1'b0, r2, 1'b1, acc);
    step(1'b0, r2, 1'b1, acc);
    checks++;
    if (delivered.size() != 3 || delivered[0] !== 2'd0 || delivered[1] !== 2'd1 ||
        delivered[2] !== 2'd2) begin
      failures++;
      $display("FAIL bp_order got count=%0d exp count=3 order 0,1,2", delivered.size());
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, rand_req(2'($urandom)), $urandom_range(0, 9) < 6, acc);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, rand_req(2'd0), 1'b1, acc);
    end
  endtask

  task automatic test_reset_full();
    bit acc;
    step(1'b1, rand_req(2'd1), 1'b0, acc);
    step(1'b1, rand_req(2'd2), 1'b0, acc);
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_full got v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
    rst = 1'b0;
    exp_q.delete();
    delivered.delete();
    step(1'b1, rand_req(2'd3), 1'b1, acc);
    step(1'b0, rand_req(2'd0), 1'b1, acc);
    step(1'b0, rand_req(2'd0), 1'b1, acc);
    checks++;
    if (delivered.size() != 1 || delivered[0] !== 2'd3) begin
      failures++;
      $display("FAIL reset_first_out got count=%0d exp count=1 pid=3", delivered.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
